// File: rtl/nibble_serial_cla_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : nsca_pkg                                                  |
// | Purpose  : Shared types and constants for the nibble-serial CLA adder|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package nsca_pkg;

  // Width of the single look-ahead slice reused every cycle
  localparam int c_NIB_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed for a given operand width
  function automatic int nibbles(input int width);
    return width / c_NIB_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_cla_adder_cla4_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cla4_slice                                                |
// | Purpose  : Combinational 4-bit carry-look-ahead adder (P/G terms)    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cla4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  // Propagate/generate terms and flattened look-ahead carries
  always_comb begin
    w_p    = i_a ^ i_b;
    w_g    = i_a & i_b;
    w_c[0] = i_cin;
    w_c[1] = w_g[0] | (w_p[0] & i_cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
    o_sum  = w_p ^ w_c[3:0];
    o_cout = w_c[4];
  end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nibble_serial_cla_adder                                   |
// | Purpose  : WIDTH-bit adder built from one 4-bit CLA slice used once  |
// |            per nibble (LSB first), with valid/ready on both sides.   |
// | Options  : NSCA_OVF_EN - adds the signed-overflow output ovf         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module nibble_serial_cla_adder
  import nsca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((WIDTH < c_NIB_W) || ((WIDTH % c_NIB_W) != 0)) begin : g_bad_width
      $error("nibble_serial_cla_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_accept;
  logic               w_add;
  logic               w_last;
  logic [3:0]         w_slice_a;
  logic [3:0]         w_slice_b;
  logic [3:0]         w_slice_sum;
  logic               w_slice_cout;
  logic [WIDTH-1:0]   w_sum_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_add        = 1'b0;
    w_last       = (r_idx == IDX_W'(NIBBLES - 1));
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ADD;
        end
      end
      ADD: begin
        w_add = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Select the current nibble and merge the slice result into the accumulator
  always_comb begin
    w_slice_a  = r_a[c_NIB_W*int'(r_idx) +: c_NIB_W];
    w_slice_b  = r_b[c_NIB_W*int'(r_idx) +: c_NIB_W];
    w_sum_next = r_acc;
    w_sum_next[c_NIB_W*int'(r_idx) +: c_NIB_W] = w_slice_sum;
  end

  cla4_slice u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Operand capture, nibble walk and result publish; partial sums stay in
  // r_acc so the visible result only changes on the final ADD edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= cin;
      r_a     <= a;
      r_b     <= b;
      r_acc   <= '0;
    end else if (w_add) begin
      r_acc   <= w_sum_next;
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_slice_cout;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef NSCA_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_add && w_last) begin
      r_ovf <= w_slice_cout ^ (r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_nibble_serial_cla_adder                                |
// | Purpose  : Directed and randomised checks of the nibble-serial adder |
// |            at WIDTH=16 and WIDTH=4.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_nibble_serial_cla_adder;

  logic        clk;
  logic        rst;

  logic        iv16, ir16, ov16, or16, cin16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, ov4, or4, cin4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef NSCA_OVF_EN
  logic        ovf16, ovf4;
`endif

  int n_checks;
  int n_pass;

  nibble_serial_cla_adder #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (sum16),
    .cout      (cout16)
`ifdef NSCA_OVF_EN
    ,
    .ovf       (ovf16)
`endif
  );

  nibble_serial_cla_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (sum4),
    .cout      (cout4)
`ifdef NSCA_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 16-bit instance; hold = cycles of DONE backpressure
  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tcin, input logic [15:0] esum, input logic ecout,
                      input logic eovf, input int hold);
    int   n;
    int   lat;
    logic busy_bad;
    logic stable_bad;
    logic [15:0] s0;
    logic c0;
    n = 0;
    while (!ir16 && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, ir16, 1);
    a16 = ta; b16 = tb; cin16 = tcin; iv16 = 1'b1;
    tick();
    iv16 = 1'b0; a16 = ~ta; b16 = 16'($urandom); cin16 = ~tcin;
    lat = 0; busy_bad = 1'b0;
    while (!ov16 && lat < 20) begin
      if (ir16) busy_bad = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_in_ready"}, busy_bad, 0);
    s0 = sum16; c0 = cout16; stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      iv16 = i[0]; a16 = 16'($urandom); b16 = 16'($urandom);
      tick();
      if (sum16 !== s0 || cout16 !== c0 || !ov16 || ir16) stable_bad = 1'b1;
    end
    iv16 = 1'b0;
    check({tag, "_hold_stable"}, stable_bad, 0);
    check({tag, "_sum"}, sum16, esum);
    check({tag, "_cout"}, cout16, ecout);
`ifdef NSCA_OVF_EN
    check({tag, "_ovf"}, ovf16, eovf);
`endif
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    check({tag, "_idle_after"}, {ov16, ir16}, 2'b01);
  endtask

  // One transaction on the 4-bit instance (single ADD cycle)
  task automatic op4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                     input logic tcin, input logic [3:0] esum, input logic ecout,
                     input logic eovf);
    int lat;
    a4 = ta; b4 = tb; cin4 = tcin; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 20) begin tick(); lat++; end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_sum"}, sum4, esum);
    check({tag, "_cout"}, cout4, ecout);
`ifdef NSCA_OVF_EN
    check({tag, "_ovf"}, ovf4, eovf);
`endif
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    check({tag, "_idle_after"}, {ov4, ir4}, 2'b01);
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, rovf;
    logic        spur;
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", ir16, 1);
    check("rst_out_valid", ov16, 0);
    check("rst_sum", sum16, 0);
    check("rst_cout", cout16, 0);
`ifdef NSCA_OVF_EN
    check("rst_ovf", ovf16, 0);
`endif
    check("rst4_ready_valid", {ir4, ov4}, 2'b10);

    // Directed vectors (expected values worked by hand)
    op16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op16("mixed",  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
    op16("bp",     16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 5);
    op16("after_bp", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 0);
    op16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op16("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op16("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    // Reset in the middle of an ADD sequence, after two nibbles
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready_valid", {ir16, ov16}, 2'b10);
    check("midrst_sum", sum16, 0);
    check("midrst_cout", cout16, 0);
    spur = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov16) spur = 1'b1;
    end
    check("midrst_no_output", spur, 0);
    op16("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    // WIDTH=4 boundary: one ADD cycle
    op4("w4_carry", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    op4("w4_cin",   4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0);
    op4("w4_plain", 4'h5, 4'h2, 1'b0, 4'h7, 1'b0, 1'b0);
    op4("w4_ovf",   4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1);

    // Random operands with random gaps and backpressure, against a + b + cin
    for (int k = 0; k < 120; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom);
      full = 17'(ra) + 17'(rb) + 17'(rc);
      rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      repeat ($urandom_range(0, 2)) tick();
      op16("rand", ra, rb, rc, full[15:0], full[16], rovf, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
